// File: rtl/dmem_write_buffer_if.sv
// MEM-stage bus between the pipeline (master) and the data memory (slave).
// Carries the address, store data, request strobes and the combinational load data.
interface dmem_write_buffer_if;
    logic [31:0] adr_Mem;
    logic [31:0] writeData_Mem;
    logic        memWrite;
    logic        memRead;
    logic [31:0] readData_Mem;

    modport master (
        output adr_Mem,
        output writeData_Mem,
        output memWrite,
        output memRead,
        input  readData_Mem
    );

    modport slave (
        input  adr_Mem,
        input  writeData_Mem,
        input  memWrite,
        input  memRead,
        output readData_Mem
    );
endinterface

// File: rtl/dmem_write_buffer.sv
// Data memory with a posted-store FIFO in front of a slow-write RAM.
// Loads are answered combinationally, forwarding the youngest matching buffered store.
module dmem_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 10,
    parameter int WR_LAT = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    dmem_write_buffer_if.slave       mem,
    output logic [$clog2(DEPTH):0]   wb_count,
    output logic                     wb_full,
    output logic                     wb_empty,
    output logic                     overflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int LAT_W = $clog2(WR_LAT + 1);

    localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(WR_LAT);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_WRITE = 1'b1;

    // Backing RAM: contents are never reset.
    logic [31:0] ram [2**ADDR_W];

    // Write-buffer storage
    logic [ADDR_W-1:0] entry_idx_reg  [DEPTH];
    logic [31:0]       entry_data_reg [DEPTH];
    logic [DEPTH-1:0]  entry_valid_reg;
    logic [DEPTH-1:0]  entry_valid_next;

    logic [PTR_W-1:0]  head_reg, head_next;
    logic [PTR_W-1:0]  tail_reg, tail_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic [0:0]        state_reg, state_next;
    logic [LAT_W-1:0]  lat_cnt_reg, lat_cnt_next;
    logic              overflow_reg, overflow_next;

    logic [ADDR_W-1:0] word_idx;
    logic              is_full;
    logic              is_empty;
    logic              commit;
    logic              push_ok;
    logic              drop;
    logic [DEPTH-1:0]  hit_vec;
    logic [31:0]       load_data;
    logic [PTR_W-1:0]  scan_slot;

    // Upper/lower address bits alias by design; memRead does not gate the read path.
    logic unused_bits;
    assign unused_bits = ^{mem.adr_Mem[31:ADDR_W+2], mem.adr_Mem[1:0], mem.memRead};

    assign word_idx = mem.adr_Mem[ADDR_W+1:2];
    assign is_full  = (count_reg == CNT_FULL);
    assign is_empty = (count_reg == '0);
    assign commit   = (state_reg == ST_WRITE) && (lat_cnt_reg == LAT_LAST);

    // A full buffer still accepts a store when the head retires on the same edge.
    assign push_ok  = mem.memWrite && (!is_full || commit);
    assign drop     = mem.memWrite && is_full && !commit;

    // ------------------------------------------------------------------
    // Load path: per-slot address match, then pick the youngest hit.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            assign hit_vec[gi] = entry_valid_reg[gi] && (entry_idx_reg[gi] == word_idx);
        end
    endgenerate

    // Scan from oldest (head) to youngest so later hits override earlier ones.
    always_comb begin
        load_data = ram[word_idx];
        scan_slot = head_reg;
        for (int k = 0; k < DEPTH; k++) begin
            scan_slot = head_reg + PTR_W'(k);
            if (hit_vec[scan_slot]) begin
                load_data = entry_data_reg[scan_slot];
            end
        end
    end

    assign mem.readData_Mem = load_data;

    // ------------------------------------------------------------------
    // Queue bookkeeping
    // ------------------------------------------------------------------
    always_comb begin
        head_next        = head_reg;
        tail_next        = tail_reg;
        entry_valid_next = entry_valid_reg;
        overflow_next    = overflow_reg | drop;

        if (commit) begin
            head_next                  = head_reg + PTR_ONE;
            entry_valid_next[head_reg] = 1'b0;
        end
        // Applied after the pop so a full-buffer push into the retiring slot wins.
        if (push_ok) begin
            tail_next                  = tail_reg + PTR_ONE;
            entry_valid_next[tail_reg] = 1'b1;
        end

        count_next = count_reg + CNT_W'(push_ok) - CNT_W'(commit);
    end

    // ------------------------------------------------------------------
    // Drain FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        lat_cnt_next = lat_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (!is_empty) begin
                    state_next   = ST_WRITE;
                    lat_cnt_next = LAT_ONE;
                end
            end
            ST_WRITE: begin
                if (!commit) begin
                    lat_cnt_next = lat_cnt_reg + LAT_ONE;
                end else if (count_next != '0) begin
                    state_next   = ST_WRITE;
                    lat_cnt_next = LAT_ONE;
                end else begin
                    state_next   = ST_IDLE;
                    lat_cnt_next = '0;
                end
            end
            default: begin
                state_next   = ST_IDLE;
                lat_cnt_next = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg        <= '0;
            tail_reg        <= '0;
            count_reg       <= '0;
            entry_valid_reg <= '0;
            state_reg       <= ST_IDLE;
            lat_cnt_reg     <= '0;
            overflow_reg    <= 1'b0;
        end else begin
            head_reg        <= head_next;
            tail_reg        <= tail_next;
            count_reg       <= count_next;
            entry_valid_reg <= entry_valid_next;
            state_reg       <= state_next;
            lat_cnt_reg     <= lat_cnt_next;
            overflow_reg    <= overflow_next;
        end
    end

    // Payload storage has no reset; validity is tracked separately.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            entry_idx_reg[tail_reg]  <= word_idx;
            entry_data_reg[tail_reg] <= mem.writeData_Mem;
        end
    end

    // A reset on the commit edge aborts the RAM write.
    always_ff @(posedge clk) begin
        if (!rst && commit) begin
            ram[entry_idx_reg[head_reg]] <= entry_data_reg[head_reg];
        end
    end

    assign wb_count = count_reg;
    assign wb_full  = is_full;
    assign wb_empty = is_empty;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_dmem_write_buffer.sv
// Directed bench for dmem_write_buffer (DEPTH=4, ADDR_W=10, WR_LAT=3).
// Each scenario task drives stimulus and checks against hand-computed values.
module tb_dmem_write_buffer;
    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] wb_count;
    logic       wb_full;
    logic       wb_empty;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    dmem_write_buffer_if mem_bus();

    dmem_write_buffer #(.DEPTH(4), .ADDR_W(10), .WR_LAT(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .mem      (mem_bus.slave),
        .wb_count (wb_count),
        .wb_full  (wb_full),
        .wb_empty (wb_empty),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        mem_bus.adr_Mem       = a;
        mem_bus.writeData_Mem = d;
        mem_bus.memWrite      = 1'b1;
        tick();
        mem_bus.memWrite      = 1'b0;
        $display("store  adr=%08h data=%08h -> wb_count=%0d overflow=%0b", a, d, wb_count, overflow);
    endtask

    task automatic load(input logic [31:0] a, output logic [31:0] d);
        mem_bus.adr_Mem = a;
        mem_bus.memRead = 1'b1;
        #1;
        d = mem_bus.readData_Mem;
        mem_bus.memRead = 1'b0;
        $display("load   adr=%08h -> data=%08h", a, d);
    endtask

    task automatic wait_empty(input int max_cycles);
        int n = 0;
        while (wb_empty !== 1'b1 && n < max_cycles) begin
            tick();
            n++;
        end
        checks++;
        if (wb_empty !== 1'b1) begin
            errors++;
            $display("FAIL drain_timeout: wb_empty=%0b after %0d cycles, required 1", wb_empty, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (wb_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d, required 0", wb_count); end
        checks++;
        if (wb_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %0b, required 1", wb_empty); end
        checks++;
        if (wb_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b, required 0", wb_full); end
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0b, required 0", overflow); end
        rst = 1'b0;
        $display("reset  released");
    endtask

    task automatic test_single_store();
        logic [31:0] d;
        store(32'h0000_0040, 32'hDEAD_BEEF);
        checks++;
        if (wb_count !== 3'd1) begin errors++; $display("FAIL single_count: got %0d, required 1", wb_count); end
        load(32'h0000_0040, d);
        checks++;
        if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_forward: got %08h, required deadbeef", d); end
        tick(); tick(); tick();
        checks++;
        if (wb_count !== 3'd1) begin errors++; $display("FAIL single_precommit: got %0d, required 1", wb_count); end
        tick();
        checks++;
        if (wb_empty !== 1'b1) begin errors++; $display("FAIL single_commit: wb_empty=%0b, required 1", wb_empty); end
        load(32'h0000_0040, d);
        checks++;
        if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_ram: got %08h, required deadbeef", d); end
        // Read path is not gated by memRead.
        mem_bus.adr_Mem = 32'h0000_0040;
        mem_bus.memRead = 1'b0;
        #1;
        checks++;
        if (mem_bus.readData_Mem !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL single_ungated: got %08h, required deadbeef", mem_bus.readData_Mem);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        store(32'h0000_0010, 32'd1);
        store(32'h0000_0010, 32'd2);
        store(32'h0000_0010, 32'd3);
        checks++;
        if (wb_count !== 3'd3) begin errors++; $display("FAIL b2b_count: got %0d, required 3", wb_count); end
        load(32'h0000_0010, d);
        checks++;
        if (d !== 32'd3) begin errors++; $display("FAIL b2b_youngest: got %08h, required 00000003", d); end
        for (int i = 0; i < 7; i++) tick();
        checks++;
        if (wb_count !== 3'd1) begin errors++; $display("FAIL b2b_two_commits: got %0d, required 1", wb_count); end
        load(32'h0000_0010, d);
        checks++;
        if (d !== 32'd3) begin errors++; $display("FAIL b2b_mid_drain: got %08h, required 00000003", d); end
        tick();
        checks++;
        if (wb_count !== 3'd0) begin errors++; $display("FAIL b2b_third_commit: got %0d, required 0", wb_count); end
        load(32'h0000_0010, d);
        checks++;
        if (d !== 32'd3) begin errors++; $display("FAIL b2b_ram: got %08h, required 00000003", d); end
    endtask

    task automatic test_full_buffer();
        logic [31:0] d;
        logic [31:0] exp_data [5];
        for (int i = 0; i < 4; i++) store(32'h0000_0100 + 32'(i * 4), 32'h0000_00A0 + 32'(i));
        checks++;
        if (wb_count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d, required 4", wb_count); end
        checks++;
        if (wb_full !== 1'b1) begin errors++; $display("FAIL full_flag: got %0b, required 1", wb_full); end
        // This edge is the first commit: the store must be accepted.
        store(32'h0000_0110, 32'h0000_00A4);
        checks++;
        if (wb_count !== 3'd4) begin errors++; $display("FAIL commit_push_count: got %0d, required 4", wb_count); end
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL commit_push_overflow: got %0b, required 0", overflow); end
        store(32'h0000_0114, 32'h0000_00A5);
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL drop_overflow: got %0b, required 1", overflow); end
        checks++;
        if (wb_full !== 1'b1 || wb_count !== 3'd4) begin
            errors++; $display("FAIL drop_full: full=%0b count=%0d, required full=1 count=4", wb_full, wb_count);
        end
        exp_data = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4};
        for (int i = 0; i < 5; i++) begin
            load(32'h0000_0100 + 32'(i * 4), d);
            checks++;
            if (d !== exp_data[i]) begin errors++; $display("FAIL full_readback%0d: got %08h, required %08h", i, d, exp_data[i]); end
        end
        wait_empty(40);
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_sticky: got %0b, required 1", overflow); end
        load(32'h0000_010C, d);
        checks++;
        if (d !== 32'hA3) begin errors++; $display("FAIL full_ram: got %08h, required 000000a3", d); end
    endtask

    task automatic test_reset_mid_drain();
        logic [31:0] d;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL overflow_cleared: got %0b, required 0", overflow); end
        store(32'h0000_0200, 32'h1111_1111);
        tick(); tick(); tick();
        checks++;
        if (wb_count !== 3'd1) begin errors++; $display("FAIL post_reset_precommit: got %0d, required 1", wb_count); end
        tick();
        checks++;
        if (wb_empty !== 1'b1) begin errors++; $display("FAIL post_reset_commit: wb_empty=%0b, required 1", wb_empty); end
        store(32'h0000_0200, 32'h2222_2222);
        store(32'h0000_0204, 32'h3333_3333);
        store(32'h0000_0208, 32'h4444_4444);
        checks++;
        if (wb_count !== 3'd3) begin errors++; $display("FAIL abort_prefill: got %0d, required 3", wb_count); end
        load(32'h0000_0200, d);
        checks++;
        if (d !== 32'h2222_2222) begin errors++; $display("FAIL abort_forward: got %08h, required 22222222", d); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (wb_count !== 3'd0 || wb_empty !== 1'b1) begin
            errors++; $display("FAIL abort_count: count=%0d empty=%0b, required 0/1", wb_count, wb_empty);
        end
        load(32'h0000_0200, d);
        checks++;
        if (d !== 32'h1111_1111) begin errors++; $display("FAIL abort_old_value: got %08h, required 11111111", d); end
        for (int i = 0; i < 6; i++) tick();
        load(32'h0000_0200, d);
        checks++;
        if (d !== 32'h1111_1111) begin errors++; $display("FAIL abort_no_late_write: got %08h, required 11111111", d); end
    endtask

    task automatic test_load_during_drain();
        logic [31:0] d;
        store(32'h0000_0300, 32'h5555_5555);
        for (int i = 0; i < 3; i++) begin
            load(32'h0000_0040, d);
            checks++;
            if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL drain_load_a%0d: got %08h, required deadbeef", i, d); end
            load(32'h0000_0010, d);
            checks++;
            if (d !== 32'd3) begin errors++; $display("FAIL drain_load_b%0d: got %08h, required 00000003", i, d); end
            tick();
        end
        checks++;
        if (wb_count !== 3'd1) begin errors++; $display("FAIL drain_timing_pre: got %0d, required 1", wb_count); end
        tick();
        checks++;
        if (wb_count !== 3'd0) begin errors++; $display("FAIL drain_timing_commit: got %0d, required 0", wb_count); end
        load(32'hFFFF_F303, d);
        checks++;
        if (d !== 32'h5555_5555) begin errors++; $display("FAIL alias_load: got %08h, required 55555555", d); end
    endtask

    initial begin
        rst                   = 1'b1;
        mem_bus.adr_Mem       = '0;
        mem_bus.writeData_Mem = '0;
        mem_bus.memWrite      = 1'b0;
        mem_bus.memRead       = 1'b0;
        test_reset();
        test_single_store();
        test_back_to_back();
        test_full_buffer();
        test_reset_mid_drain();
        test_load_during_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
